// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start(0), 8 data bits LSB first, optional odd parity, stop(1).
// One byte per valid/ready handshake; back-to-back frames with no idle gap.
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;

  logic last_baud;
  logic accept;

  assign last_baud = (baud_q == BAUD_MAX);
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_STOP) && last_baud);
  assign done      = (state_q == S_STOP) && last_baud;
  assign busy      = (state_q != S_IDLE);
  assign tx        = tx_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    baud_d  = 16'd0;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    if (state_q != S_IDLE) begin
      baud_d = last_baud ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (last_baud) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (last_baud) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (last_baud) state_d = S_STOP;
      end
      S_STOP: begin
        if (last_baud) state_d = accept ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      shreg_d = in_data;
      par_d   = ~^in_data;
    end

    // Line level is registered from the next state so it changes with the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations checked cycle by cycle
// against a frame model built from the start/data/parity/stop bit layout.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din [3];
  logic [2:0] vld = 3'b000;
  logic [2:0] rdy_w, tx_w, busy_w, done_w;

  int total = 0;
  int bad = 0;
  int done_cnt [3] = '{0, 0, 0};
  int exp_done [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) u0 (
    .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  serial_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u2 (
    .clk(clk), .reset(reset), .in_data(din[2]), .in_valid(vld[2]),
    .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (done_w[u] === 1'b1) done_cnt[u] <= done_cnt[u] + 1;
    end
  end

  // Bit n of the frame for byte d: start, data LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int p, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if (p != 0 && n == 9) return (ones % 2 == 0) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  // Waits for acceptance of din[u]/vld[u] (already driven at a falling edge),
  // then checks every cycle of the frame.
  task automatic xfer(input int u, input logic [7:0] d, input int c, input int p,
                      input bit hold, input logic [7:0] nd, input bit glitch);
    int len;
    int waited;
    logic exp_tx;
    logic exp_last;
    len = (10 + p) * c;
    waited = 0;
    while (rdy_w[u] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", rdy_w[u], 1'b1);
    @(posedge clk);
    #1;
    if (hold) din[u] = nd;
    else vld[u] = 1'b0;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      if (glitch && j == 3) begin
        din[u] = 8'h55;
        vld[u] = 1'b1;
      end
      if (glitch && j == 4) vld[u] = 1'b0;
      exp_tx   = frame_bit(d, p, (j - 1) / c);
      exp_last = (j == len);
      total += 4;
      if (tx_w[u] !== exp_tx) begin
        bad++;
        $error("FAIL tx_bit observed=%0h expected=%0h", tx_w[u], exp_tx);
      end
      if (busy_w[u] !== 1'b1) begin
        bad++;
        $error("FAIL busy observed=%0h expected=%0h", busy_w[u], 1'b1);
      end
      if (done_w[u] !== exp_last) begin
        bad++;
        $error("FAIL done observed=%0h expected=%0h", done_w[u], exp_last);
      end
      if (rdy_w[u] !== exp_last) begin
        bad++;
        $error("FAIL in_ready observed=%0h expected=%0h", rdy_w[u], exp_last);
      end
    end
    exp_done[u]++;
    if (!hold) begin
      @(negedge clk);
      chk("idle_busy", busy_w[u], 1'b0);
      chk("idle_tx", tx_w[u], 1'b1);
      chk("idle_ready", rdy_w[u], 1'b1);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int cs [3] = '{1, 4, 2};
    int ps [3] = '{1, 1, 0};
    for (int u = 0; u < 3; u++) din[u] = 8'h00;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_tx", tx_w[u], 1'b1);
      chk("rst_ready", rdy_w[u], 1'b1);
      chk("rst_busy", busy_w[u], 1'b0);
      chk("rst_done", done_w[u], 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed frames from the test plan.
    din[0] = 8'hA5; vld[0] = 1'b1;
    xfer(0, 8'hA5, 1, 1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    din[0] = 8'h01; vld[0] = 1'b1;
    xfer(0, 8'h01, 1, 1, 1'b1, 8'hFF, 1'b0);
    xfer(0, 8'hFF, 1, 1, 1'b0, 8'h00, 1'b0);
    din[1] = 8'h01; vld[1] = 1'b1;
    xfer(1, 8'h01, 4, 1, 1'b0, 8'h00, 1'b0);
    din[2] = 8'h80; vld[2] = 1'b1;
    xfer(2, 8'h80, 2, 0, 1'b0, 8'h00, 1'b0);

    // In-frame valid pulse must be ignored.
    din[0] = 8'hC3; vld[0] = 1'b1;
    xfer(0, 8'hC3, 1, 1, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("no_extra_frame_busy", busy_w[0], 1'b0);
    chk("no_extra_frame_tx", tx_w[0], 1'b1);

    // Reset in the middle of a frame.
    din[0] = 8'hF0; vld[0] = 1'b1;
    while (rdy_w[0] !== 1'b1) @(negedge clk);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("pre_reset_tx", tx_w[0], frame_bit(8'hF0, 1, j - 1));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx_w[0], 1'b1);
    chk("abort_ready", rdy_w[0], 1'b1);
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_done", done_w[0], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    din[0] = 8'h3C; vld[0] = 1'b1;
    xfer(0, 8'h3C, 1, 1, 1'b0, 8'h00, 1'b0);

    // Randomized bytes, sometimes back-to-back, on every configuration.
    for (int u = 0; u < 3; u++) begin
      a = 8'($urandom);
      din[u] = a; vld[u] = 1'b1;
      for (int n = 0; n < 6; n++) begin
        b = 8'($urandom);
        if (n < 5 && $urandom_range(1, 0) == 1) begin
          xfer(u, a, cs[u], ps[u], 1'b1, b, 1'b0);
          a = b;
        end else begin
          xfer(u, a, cs[u], ps[u], 1'b0, 8'h00, 1'b0);
          if (n < 5) begin
            a = b;
            din[u] = a; vld[u] = 1'b1;
          end
        end
      end
      vld[u] = 1'b0;
    end

    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("done_count", done_cnt[u], exp_done[u]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that takes one byte per valid/ready handshake and shifts it onto a single-wire line. The frame is: start bit (0), 8 data bits LSB first, optional odd-parity bit, stop bit (1). It is the transmit end of the team's serial link and produces exactly the frame format our serial-data receiver FSM consumes. It sits between a byte producer (upstream, valid/ready) and the `tx` pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles each bit is held on `tx`. Legal range is 1..65535.
- `PARITY_EN`, default 1: 1 inserts an odd-parity bit between the data and stop bits; 0 omits it.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_data`, input, 8: byte to send. Sampled only on the accept edge.
- `in_valid`, input, 1: upstream has a byte. Upstream must hold `in_valid` and `in_data` stable until accepted.
- `in_ready`, output, 1: the block can accept a byte this cycle.
- `tx`, output, 1: serial line. Idles high.
- `busy`, output, 1: a frame is in progress (state is not IDLE).
- `done`, output, 1: one-cycle pulse during the final clock of a stop bit.

## Operation

Reset values:
- `tx`=1, `in_ready`=1, `busy`=0, `done`=0.
- State is IDLE; bit counter and baud counter are 0.

State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE or START.
- PARITY is skipped when `PARITY_EN`=0.

Accept:
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- `in_data` is copied into an 8-bit shift register.
- Parity is latched as `~^in_data` (odd parity: total ones in data plus parity bit is odd).

Per-state `tx` value:
- START: 0.
- DATA: `shreg[0]`; shift right after each bit.
- PARITY: the latched parity bit.
- STOP: 1.
- IDLE: 1.

Counters:
- Each state lasts `CLKS_PER_BIT` cycles, counted by a baud counter that wraps from `CLKS_PER_BIT-1` to 0.
- DATA additionally counts 8 bits (0..7) before leaving the state.

`in_ready` is 1 in IDLE and in the last cycle of STOP; it is 0 otherwise.

Back-to-back frames:
- If a byte is accepted in the last STOP cycle, the next state is START with no idle gap.
- Otherwise the next state is IDLE.

`done` is 1 in exactly the last cycle of STOP, once per completed frame.

`in_valid` while `in_ready`=0 has no effect; the byte is neither captured nor dropped.

Reset mid-frame:
- The frame is aborted and `tx` returns to 1 on the next cycle.
- No `done` pulse is produced, and the partial byte is discarded.

Outputs are registered (`tx`, `done`, `in_ready` decoded from registered state). There are no combinational paths from inputs to outputs.

## Timing

- Accept edge is k. Let C = `CLKS_PER_BIT`.
- `tx`=0 during cycles k+1 .. k+C.
- Data bit i (i=0..7) is on `tx` during cycles k+1+C(1+i) .. k+C(2+i).
- Parity, if enabled, occupies the next C cycles.
- Stop occupies the following C cycles.
- Frame length is (10 + `PARITY_EN`)·C cycles from k+1.
- `busy` rises at k+1 and falls one cycle after the last STOP cycle, unless back-to-back.
- Maximum throughput is one byte per (10 + `PARITY_EN`)·C cycles.

## Test plan

- C=1, `PARITY_EN`=1, send 0xA5 -> `tx` over cycles k+1..k+11 is 0,1,0,1,0,0,1,0,1,1,1. `done` is high only at k+11.
- C=1, `in_valid` held high with 0x01 then 0xFF -> second frame's start bit is at k+12 with no idle cycle. Parity bits are 0 then 1. Two `done` pulses, 11 cycles apart.
- C=4, `PARITY_EN`=1, send 0x01 -> `tx` low for 4 cycles, then 1 for 4 cycles, then 0 for 28 cycles, then parity 0 for 4 cycles, then 1. `busy` is high for 44 cycles.
- `PARITY_EN`=0, C=2, send 0x80 -> 20-cycle frame: start(2), seven 0 bits(14), a 1 bit(2), stop(2). No parity slot.
- Assert `reset` on cycle 5 of a C=1 frame -> next cycle `tx`=1, `in_ready`=1, `busy`=0, no `done`. A fresh 0x3C afterwards transmits correctly.
- Pulse `in_valid` with 0x55 while `busy` mid-frame (`in_ready`=0) -> the current frame is unaffected, 0x55 is not transmitted, and `done` count equals accepted count.
